alu_ctrl_seq: RTL and testbench

- Registered, handshaked ALU control decoder for the RV32 core, extended to the full RV32I ALU set plus the M-extension (mul/div).
- Sits between the main decoder and the execute stage.
- Accepts one decode request per valid/ready handshake and emits a registered ALU control code, an M-extension select and an illegal flag.
- For mul/div operations it holds its output until a parametrised iterative-unit latency has elapsed.

---
 rtl/alu_ctrl_seq.sv | 167 ++++++++++++++++
 tb/tb_alu_ctrl_seq.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_seq.sv
// Registered RV32I/M ALU control decoder with valid/ready handshakes on both sides.
// Latency: base/illegal ops 1 cycle, mul class MUL_LATENCY, div class DIV_LATENCY.
// Backpressure: output is held until out_ready; in_ready only when idle or the result drains this cycle.
module alu_ctrl_seq #(
    parameter int CTRL_W      = 4,
    parameter int EN_M        = 1,
    parameter int MUL_LATENCY = 4,
    parameter int DIV_LATENCY = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        aluop,
    input  logic [6:0]        funct7,
    input  logic              op5,
    input  logic [2:0]        funct3,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] alu_ctrl,
    output logic              md_sel,
    output logic [2:0]        md_op,
    output logic              illegal,
    output logic              md_start,
    output logic              busy
);
    localparam int MAX_LAT = (MUL_LATENCY > DIV_LATENCY) ? MUL_LATENCY : DIV_LATENCY;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLT  = 4'd5;
    localparam logic [3:0] OP_SLTU = 4'd6;
    localparam logic [3:0] OP_SLL  = 4'd7;
    localparam logic [3:0] OP_SRL  = 4'd8;
    localparam logic [3:0] OP_SRA  = 4'd9;

    typedef enum logic [1:0] {IDLE, WAIT, VALID} state_t;

    typedef struct packed {
        logic [3:0] code;
        logic       md_sel;
        logic [2:0] md_op;
        logic       illegal;
    } dec_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n, md_cnt;
    logic              load, md_direct;
    logic              f7_zero, f7_alt, f7_m, is_md, bad;
    dec_t              dec;

    always_comb begin
        f7_zero = (funct7 == 7'b0000000);
        f7_alt  = (funct7 == 7'b0100000);
        f7_m    = (funct7 == 7'b0000001);
        is_md   = op5 && f7_m && (EN_M != 0);
        // M ops are recognised first; funct3 checks below only police base encodings.
        bad = (op5 && !(f7_zero || f7_alt || is_md))
            || (op5 && f7_alt && (funct3 != 3'b000) && (funct3 != 3'b101))
            || ((funct3 == 3'b001) && !f7_zero)
            || ((funct3 == 3'b101) && !f7_zero && !f7_alt);
        dec = '0;
        case (aluop)
            2'b00: dec.code = OP_ADD;
            2'b01: dec.code = OP_SUB;
            2'b11: dec.illegal = 1'b1;
            default: begin
                if (is_md) begin
                    dec.md_sel = 1'b1;
                    dec.md_op  = funct3;
                end else if (bad) begin
                    dec.illegal = 1'b1;
                end else begin
                    case (funct3)
                        3'b000:  dec.code = (op5 && f7_alt) ? OP_SUB : OP_ADD;
                        3'b001:  dec.code = OP_SLL;
                        3'b010:  dec.code = OP_SLT;
                        3'b011:  dec.code = OP_SLTU;
                        3'b100:  dec.code = OP_XOR;
                        3'b101:  dec.code = f7_alt ? OP_SRA : OP_SRL;
                        3'b110:  dec.code = OP_OR;
                        default: dec.code = OP_AND;
                    endcase
                end
            end
        endcase
    end

    // Counter holds cycles remaining until out_valid, as seen in the first WAIT cycle.
    always_comb begin
        md_cnt    = funct3[2] ? CNT_W'(DIV_LATENCY - 1) : CNT_W'(MUL_LATENCY - 1);
        md_direct = (md_cnt == '0);
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        load     = 1'b0;
        in_ready = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                load     = in_valid;
            end
            WAIT: begin
                if (cnt <= CNT_W'(1)) begin
                    state_n = VALID;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            VALID: begin
                in_ready = out_ready;
                if (out_ready) begin
                    load = in_valid;
                    if (!in_valid) state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        if (load) begin
            if (dec.md_sel && !md_direct) begin
                state_n = WAIT;
                cnt_n   = md_cnt;
            end else begin
                state_n = VALID;
                cnt_n   = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            alu_ctrl <= '0;
            md_sel   <= 1'b0;
            md_op    <= 3'b000;
            illegal  <= 1'b0;
            md_start <= 1'b0;
        end else begin
            md_start <= load && dec.md_sel;
            if (load) begin
                alu_ctrl <= CTRL_W'(dec.code);
                md_sel   <= dec.md_sel;
                md_op    <= dec.md_op;
                illegal  <= dec.illegal;
            end
        end
    end

    assign out_valid = (state == VALID);
    assign busy      = (state == WAIT);
endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Scoreboard bench for alu_ctrl_seq: expected decodes are queued at accept and
// compared (with accept-to-valid latency) when the result is presented.
module tb_alu_ctrl_seq;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0, in_ready, op5 = 1'b0, out_valid, out_ready = 1'b1;
    logic [1:0] aluop = 2'b00;
    logic [6:0] funct7 = 7'h00;
    logic [2:0] funct3 = 3'b000, md_op;
    logic [3:0] alu_ctrl;
    logic       md_sel, illegal, md_start, busy;

    logic       nm_in_valid = 1'b0, nm_in_ready, nm_op5 = 1'b0, nm_out_valid;
    logic [1:0] nm_aluop = 2'b00;
    logic [6:0] nm_funct7 = 7'h00;
    logic [2:0] nm_funct3 = 3'b000, nm_md_op;
    logic [4:0] nm_alu_ctrl;
    logic       nm_md_sel, nm_illegal, nm_md_start, nm_busy;

    typedef struct {
        logic [3:0] code;
        logic       md_sel;
        logic [2:0] md_op;
        logic       ill;
        int         first;
    } exp_t;

    exp_t sbq[$];
    bit   head_seen = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_ctrl_seq #(.CTRL_W(4), .EN_M(1), .MUL_LATENCY(4), .DIV_LATENCY(32)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .aluop(aluop), .funct7(funct7), .op5(op5), .funct3(funct3),
        .out_valid(out_valid), .out_ready(out_ready), .alu_ctrl(alu_ctrl),
        .md_sel(md_sel), .md_op(md_op), .illegal(illegal),
        .md_start(md_start), .busy(busy)
    );

    alu_ctrl_seq #(.CTRL_W(5), .EN_M(0), .MUL_LATENCY(2), .DIV_LATENCY(3)) u_nom (
        .clk(clk), .reset(reset), .in_valid(nm_in_valid), .in_ready(nm_in_ready),
        .aluop(nm_aluop), .funct7(nm_funct7), .op5(nm_op5), .funct3(nm_funct3),
        .out_valid(nm_out_valid), .out_ready(1'b1), .alu_ctrl(nm_alu_ctrl),
        .md_sel(nm_md_sel), .md_op(nm_md_op), .illegal(nm_illegal),
        .md_start(nm_md_start), .busy(nm_busy)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Result monitor: latency on first presentation, fields every cycle while held.
    always @(negedge clk) begin
        if (reset) begin
            head_seen = 1'b0;
        end else if (out_valid) begin
            if (sbq.size() == 0) begin
                chk("spurious_valid", out_valid, 1'b0);
            end else begin
                if (!head_seen) begin
                    chk("latency", cyc, sbq[0].first);
                    head_seen = 1'b1;
                end
                chk("alu_ctrl", alu_ctrl, sbq[0].code);
                chk("md_sel", md_sel, sbq[0].md_sel);
                chk("md_op", md_op, sbq[0].md_op);
                chk("illegal", illegal, sbq[0].ill);
                if (out_ready) begin
                    void'(sbq.pop_front());
                    head_seen = 1'b0;
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accept edge.
    task automatic send(input logic [1:0] op, input logic [6:0] f7, input logic o5,
                        input logic [2:0] f3, input logic [3:0] ecode, input logic emd,
                        input logic eill, input int lat, output int waits);
        exp_t e;
        bit   done;
        done  = 1'b0;
        waits = 0;
        aluop = op; funct7 = f7; op5 = o5; funct3 = f3; in_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                e.code   = ecode;
                e.md_sel = emd;
                e.md_op  = emd ? f3 : 3'b000;
                e.ill    = eill;
                e.first  = cyc + lat;
                sbq.push_back(e);
                done = 1'b1;
            end else if (waits >= 100) begin
                chk("accept_timeout", in_ready, 1'b1);
                done = 1'b1;
            end else begin
                waits++;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic idle_in();
        in_valid = 1'b0;
        funct7   = 7'($urandom_range(0, 127));
        funct3   = 3'($urandom_range(0, 7));
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sbq.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("drain", sbq.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_out_valid"}, out_valid, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_in_ready"}, in_ready, 1'b1);
        chk({tag, "_alu_ctrl"}, alu_ctrl, 4'd0);
        chk({tag, "_md_sel"}, md_sel, 1'b0);
        chk({tag, "_md_op"}, md_op, 3'd0);
        chk({tag, "_illegal"}, illegal, 1'b0);
        chk({tag, "_md_start"}, md_start, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_idle("rst0");
        @(posedge clk); #1;

        // Individual decodes, streamed back to back.
        send(2'b00, 7'h00,      1'b0, 3'b010, 4'd0, 1'b0, 1'b0, 1,  w);
        send(2'b01, 7'h7f,      1'b1, 3'b111, 4'd1, 1'b0, 1'b0, 1,  w);
        send(2'b10, 7'b0100000, 1'b1, 3'b000, 4'd1, 1'b0, 1'b0, 1,  w);
        send(2'b10, 7'b0100000, 1'b0, 3'b000, 4'd0, 1'b0, 1'b0, 1,  w);
        send(2'b10, 7'b0100000, 1'b1, 3'b101, 4'd9, 1'b0, 1'b0, 1,  w);
        send(2'b10, 7'b0000000, 1'b1, 3'b101, 4'd8, 1'b0, 1'b0, 1,  w);
        send(2'b10, 7'b0000000, 1'b0, 3'b001, 4'd7, 1'b0, 1'b0, 1,  w);
        send(2'b10, 7'b0100000, 1'b0, 3'b101, 4'd9, 1'b0, 1'b0, 1,  w);
        send(2'b11, 7'b0000000, 1'b1, 3'b000, 4'd0, 1'b0, 1'b1, 1,  w);
        send(2'b10, 7'b0100000, 1'b1, 3'b001, 4'd0, 1'b0, 1'b1, 1,  w);
        send(2'b10, 7'b0000010, 1'b1, 3'b000, 4'd0, 1'b0, 1'b1, 1,  w);
        send(2'b10, 7'b0100000, 1'b1, 3'b110, 4'd0, 1'b0, 1'b1, 1,  w);
        send(2'b10, 7'b0000001, 1'b0, 3'b101, 4'd0, 1'b0, 1'b1, 1,  w);
        send(2'b10, 7'b0000001, 1'b1, 3'b001, 4'd0, 1'b1, 1'b0, 4,  w);
        send(2'b10, 7'b0000001, 1'b1, 3'b110, 4'd0, 1'b1, 1'b0, 32, w);
        send(2'b10, 7'b1111111, 1'b0, 3'b110, 4'd3, 1'b0, 1'b0, 1,  w);
        idle_in();
        drain();

        // Full-rate stream: add, slt, sltu, xor, or, and.
        send(2'b10, 7'h00, 1'b1, 3'b000, 4'd0, 1'b0, 1'b0, 1, w); chk("stream_rdy0", w, 0);
        send(2'b10, 7'h00, 1'b1, 3'b010, 4'd5, 1'b0, 1'b0, 1, w); chk("stream_rdy1", w, 0);
        send(2'b10, 7'h00, 1'b1, 3'b011, 4'd6, 1'b0, 1'b0, 1, w); chk("stream_rdy2", w, 0);
        send(2'b10, 7'h00, 1'b1, 3'b100, 4'd4, 1'b0, 1'b0, 1, w); chk("stream_rdy3", w, 0);
        send(2'b10, 7'h00, 1'b1, 3'b110, 4'd3, 1'b0, 1'b0, 1, w); chk("stream_rdy4", w, 0);
        send(2'b10, 7'h00, 1'b1, 3'b111, 4'd2, 1'b0, 1'b0, 1, w); chk("stream_rdy5", w, 0);
        idle_in();
        drain();

        // mul timing: md_start cycle 1, busy 1..3, out_valid at 4.
        send(2'b10, 7'b0000001, 1'b1, 3'b000, 4'd0, 1'b1, 1'b0, 4, w);
        idle_in();
        @(negedge clk);
        chk("mul_start_c1", md_start, 1'b1);
        chk("mul_busy_c1", busy, 1'b1);
        chk("mul_valid_c1", out_valid, 1'b0);
        @(negedge clk);
        chk("mul_start_c2", md_start, 1'b0);
        chk("mul_busy_c2", busy, 1'b1);
        @(negedge clk);
        chk("mul_busy_c3", busy, 1'b1);
        @(negedge clk);
        chk("mul_busy_c4", busy, 1'b0);
        chk("mul_valid_c4", out_valid, 1'b1);
        @(posedge clk); #1;
        drain();

        // divu with output stalled until cycle 40.
        out_ready = 1'b0;
        send(2'b10, 7'b0000001, 1'b1, 3'b101, 4'd0, 1'b1, 1'b0, 32, w);
        idle_in();
        for (int k = 1; k <= 39; k++) begin
            @(negedge clk);
            chk("divu_in_ready", in_ready, 1'b0);
            chk("divu_out_valid", out_valid, (k >= 32) ? 1'b1 : 1'b0);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        chk("divu_c40_in_ready", in_ready, 1'b1);
        chk("divu_c40_valid", out_valid, 1'b1);
        @(posedge clk); #1;
        drain();

        // Reset held 2 cycles while a div is waiting; the request is discarded.
        send(2'b10, 7'b0000001, 1'b1, 3'b100, 4'd0, 1'b1, 1'b0, 32, w);
        idle_in();
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", busy, 1'b1);
        @(posedge clk); #1 reset = 1'b1;
        sbq.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_idle("rst_wait");
        repeat (40) @(negedge clk);
        chk("no_ghost_valid", out_valid, 1'b0);
        @(posedge clk); #1;

        // M encoding with the extension disabled decodes as illegal.
        nm_aluop = 2'b10; nm_funct7 = 7'b0000001; nm_op5 = 1'b1; nm_funct3 = 3'b000;
        nm_in_valid = 1'b1;
        @(negedge clk);
        chk("nom_in_ready", nm_in_ready, 1'b1);
        @(posedge clk); #1 nm_in_valid = 1'b0;
        @(negedge clk);
        chk("nom_valid", nm_out_valid, 1'b1);
        chk("nom_illegal", nm_illegal, 1'b1);
        chk("nom_md_sel", nm_md_sel, 1'b0);
        chk("nom_md_op", nm_md_op, 3'd0);
        chk("nom_alu_ctrl", nm_alu_ctrl, 5'd0);
        chk("nom_md_start", nm_md_start, 1'b0);
        chk("nom_busy", nm_busy, 1'b0);
        @(posedge clk); #1;

        drain();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
